ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_timer.sv | 36 +++
 rtl/ifetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// State encoding, fault codes and the NOP filler instruction.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_MISAL = 2'b01;
  localparam logic [1:0] FLT_RANGE = 2'b10;
  localparam logic [1:0] FLT_TMO   = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_timer.sv
// Response timer: counts enabled cycles, flags the TIMEOUT-th one.
// Cleared whenever no response is pending.
module ifetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request,
// fault reporting, flush handling and response timeout.
module ifetch_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [1:0]        fault
);

  import ifetch_pkg::*;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         ipc_q, ipc_d;
  logic                ivalid_q, ivalid_d;
  logic [1:0]          fault_q, fault_d;
  logic                kill_q, kill_d;

  logic fetch_ready, accept, misal, range_err;
  logic pending, expire;

  assign fetch_ready = (state_q == S_IDLE) &&
                       (!ivalid_q || instr_ready) && !flush;
  assign accept    = pc_valid && fetch_ready;
  assign misal     = |pc[1:0];
  assign range_err = |pc[31:ADDR_W+2];
  assign pending   = (state_q == S_WAIT) || (state_q == S_DROP);

  ifetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!pending),
    .enable (pending),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    ivalid_d = ivalid_q;
    fault_d  = fault_q;
    kill_d   = kill_q;

    if (flush || (ivalid_q && instr_ready)) begin
      ivalid_d = 1'b0;
    end
    if (accept) begin
      pc_d   = pc;
      addr_d = pc[ADDR_W+1:2];
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misal || range_err) begin
            ivalid_d = 1'b1;
            instr_d  = NOP;
            ipc_d    = pc;
            fault_d  = misal ? FLT_MISAL : FLT_RANGE;
          end else begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end
        end
      end
      S_REQ: begin
        // A flush cannot retract the request; remember it until granted.
        if (flush) kill_d = 1'b1;
        if (imem_gnt) state_d = (kill_q || flush) ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = (imem_rvalid || expire) ? S_IDLE : S_DROP;
        end else if (imem_rvalid) begin
          state_d  = S_IDLE;
          ivalid_d = 1'b1;
          instr_d  = imem_rdata;
          ipc_d    = pc_q;
          fault_d  = FLT_NONE;
        end else if (expire) begin
          state_d  = S_IDLE;
          ivalid_d = 1'b1;
          instr_d  = NOP;
          ipc_d    = pc_q;
          fault_d  = FLT_TMO;
        end
      end
      S_DROP: begin
        if (imem_rvalid || expire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      ipc_q    <= '0;
      ivalid_q <= 1'b0;
      fault_q  <= FLT_NONE;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ivalid_q <= ivalid_d;
      fault_q  <= fault_d;
      kill_q   <= kill_d;
    end
  end

  assign stall       = pc_valid && !fetch_ready;
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = ivalid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: vector table plus corner-case sequences,
// results checked against a scoreboard queue on each consume.
module tb_ifetch_ctrl;

  localparam int AW  = 14;
  localparam int TMO = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc = '0;
  logic          pc_valid = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [1:0]    fault;

  always #5 clock = ~clock;

  ifetch_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fault       (fault)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          gd;
    int          rd;
    logic [31:0] rdata;
    logic [31:0] ei;
    logic [1:0]  ef;
    bit          req;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_instr: got instr %h pc %h, want none",
                 instr, instr_pc);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("instr_pc", instr_pc, e.pc);
        chk("fault", 32'(fault), 32'(e.fault));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int  lat;
    int  exp_lat;
    bit  acc;
    bit  got;
    if (!v.req) exp_lat = 1;
    else if (v.rd < TMO) exp_lat = 3 + v.gd + v.rd;
    else exp_lat = 2 + v.gd + TMO;
    pc = v.pc;
    pc_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clock);
      if (!stall) acc = 1'b1;
      else step();
    end
    chk("accept", 32'(acc), 32'd1);
    if (acc) sb.push_back('{v.ei, v.pc, v.ef});
    step();
    pc_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      imem_gnt    = v.req && (c == 1 + v.gd);
      imem_rvalid = v.req && (v.rd < TMO) && (c == 2 + v.gd + v.rd);
      imem_rdata  = v.rdata;
      @(negedge clock);
      if (c <= 1 + v.gd) begin
        chk("imem_req", 32'(imem_req), 32'(v.req));
        if (v.req) chk("imem_addr", 32'(imem_addr), 32'(v.pc[AW+1:2]));
      end
      if (instr_valid) begin
        got = 1'b1;
        lat = c;
      end
      step();
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    if (v.req && v.rd >= TMO) begin
      // late response after a timeout must be ignored
      step();
      imem_rvalid = 1'b1;
      imem_rdata = 32'hBAAD_F00D;
      step();
      imem_rvalid = 1'b0;
      repeat (3) step();
      @(negedge clock);
      chk("late_rvalid_valid", 32'(instr_valid), 32'd0);
      step();
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h10, 0, 0, 32'h00A00093, 32'h00A00093, 2'b00, 1'b1};
    vecs[1] = '{32'h06, 0, 0, 32'h0, NOP, 2'b01, 1'b0};
    vecs[2] = '{32'h10000, 0, 0, 32'h0, NOP, 2'b10, 1'b0};
    vecs[3] = '{32'h20, 2, 3, 32'h12345678, 32'h12345678, 2'b00, 1'b1};
    vecs[4] = '{32'h10001, 0, 0, 32'h0, NOP, 2'b01, 1'b0};
    vecs[5] = '{32'hFFFC, 1, 0, 32'hCAFEBABE, 32'hCAFEBABE, 2'b00, 1'b1};
    vecs[6] = '{32'h80000000, 0, 0, 32'h0, NOP, 2'b10, 1'b0};
    vecs[7] = '{32'h04, 0, 15, 32'h11111111, 32'h11111111, 2'b00, 1'b1};
    vecs[8] = '{32'h08, 0, 16, 32'h22222222, NOP, 2'b11, 1'b1};

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    step();
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // flush while waiting; response two cycles later is dropped
    pc = 32'h40;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_rvalid = 1'b0;
    @(negedge clock);
    chk("flush_wait_valid", 32'(instr_valid), 32'd0);
    repeat (3) step();
    run_vec('{32'h20, 0, 0, 32'h00100113, 32'h00100113, 2'b00, 1'b1});

    // flush in WAIT with no response: DROP times out silently
    pc = 32'h44;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_vec('{32'h48, 0, 1, 32'h00400293, 32'h00400293, 2'b00, 1'b1});

    // flush while requesting: request held until grant, then dropped
    pc = 32'h50;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    chk("req_flush_hold0", 32'(imem_req), 32'd1);
    step();
    flush = 1'b0;
    @(negedge clock);
    chk("req_flush_hold1", 32'(imem_req), 32'd1);
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0BAD0BAD;
    step();
    imem_rvalid = 1'b0;
    @(negedge clock);
    chk("req_flush_valid", 32'(instr_valid), 32'd0);
    chk("req_flush_req", 32'(imem_req), 32'd0);
    step();

    // held result with decode stalled, then consume and accept together
    instr_ready = 1'b0;
    pc = 32'h30;
    pc_valid = 1'b1;
    sb.push_back('{32'h00200193, 32'h30, 2'b00});
    step();
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00200193;
    step();
    imem_rvalid = 1'b0;
    pc = 32'h34;
    pc_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, 32'h00200193);
      chk("hold_req", 32'(imem_req), 32'd0);
      step();
    end
    instr_ready = 1'b1;
    @(negedge clock);
    chk("release_stall", 32'(stall), 32'd0);
    sb.push_back('{32'h00300213, 32'h34, 2'b00});
    step();
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00300213;
    step();
    imem_rvalid = 1'b0;
    repeat (2) step();
    chk("hold_sb_drained", 32'(sb.size()), 32'd0);

    // flush in IDLE clears a held fault and blocks accept
    instr_ready = 1'b0;
    pc = 32'h02;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    @(negedge clock);
    chk("idle_fault_valid", 32'(instr_valid), 32'd1);
    chk("idle_fault_code", 32'(fault), 32'd1);
    step();
    flush = 1'b1;
    pc = 32'h60;
    pc_valid = 1'b1;
    @(negedge clock);
    chk("idle_flush_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0;
    pc_valid = 1'b0;
    @(negedge clock);
    chk("idle_flush_valid", 32'(instr_valid), 32'd0);
    chk("idle_flush_req", 32'(imem_req), 32'd0);
    step();
    instr_ready = 1'b1;

    // reset while waiting abandons the fetch
    pc = 32'h70;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clock);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hFEEDFACE;
    step();
    imem_rvalid = 1'b0;
    @(negedge clock);
    chk("midrst_late_valid", 32'(instr_valid), 32'd0);
    step();
    run_vec('{32'h74, 1, 2, 32'h00500313, 32'h00500313, 2'b00, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
